alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequential front-end for the combinational 8-bit ALU. Accepts operations (command, A, B) over a valid/ready interface and buffers them in a small FIFO. Issues one operation at a time to the ALU, drives its operands, command and output-enable, and captures the 16-bit result into a registered valid/ready result port. Divide-by-zero is trapped locally and never issued to the ALU.

Parameters:
DEPTH, 4, operation FIFO depth in entries; must be a power of 2 and at least 2.
AW, 2, FIFO pointer width; AW = log2(DEPTH).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operation offered.
in_ready  output  1  FIFO can accept; equals !fifo_full.
in_cmd  input  4  ALU opcode.
in_a  input  8  operand A.
in_b  input  8  operand B.
alu_a  output  8  to ALU A.
alu_b  output  8  to ALU B.
alu_cmd  output  4  to ALU command.
alu_oe  output  1  to ALU oe; high only while sampling.
alu_dout  input  16  from ALU dout; hi-Z whenever alu_oe=0.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
res_data  output  16  captured result.
res_cmd  output  4  opcode that produced res_data.
res_err  output  1  high when the result is from a trapped divide-by-zero.

Behaviour:
- Reset: all outputs are 0 except in_ready. in_ready = 1 when rst_n is high and the FIFO is empty. FIFO pointers and count are cleared, the op register is cleared, and the state is IDLE.
- Reset mid-operation: any in-flight operation and all queued operations are discarded. alu_oe drops to 0 immediately (asynchronously).
- Push: the FIFO is written when in_valid && in_ready at a clock edge. in_ready is registered-full based. When full, no push occurs, even if a pop happens in the same cycle.
- Pop: the head of the FIFO moves into the op register {cmd, a, b} at the same edge as the IDLE->DRIVE or RESP->DRIVE transition.
- alu_a, alu_b and alu_cmd always reflect the op register. They are stable for the whole of DRIVE.
- State IDLE: if the FIFO is non-empty, pop and go to DRIVE.
- State DRIVE (exactly one cycle):
  - Normal operation: alu_oe = 1. At the end of the cycle, res_data <= alu_dout, res_cmd <= cmd, res_err <= 0, res_valid <= 1; go to RESP.
  - If cmd = DIV (4'b0101) and b = 0: alu_oe stays 0. res_data <= 16'hFFFF, res_err <= 1, res_valid <= 1; go to RESP.
- State RESP: hold res_* stable while res_ready = 0. On res_valid && res_ready:
  - res_valid <= 0.
  - If the FIFO is non-empty, pop and go to DRIVE (back-to-back issue).
  - Otherwise go to IDLE.
- Latency: an operation accepted at edge k into an idle, empty block gives res_valid high in cycle k+3.
- Throughput: one result per 2 cycles when res_ready is held high.
- Capacity: DEPTH queued operations plus 1 in the op register. With res_ready = 0 from reset, DEPTH+1 operations are accepted, then in_ready = 0.
- Wrap-around: pointers are AW bits and wrap naturally. A count of AW+1 bits determines full (count = DEPTH) and empty (count = 0).
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both happen.
- No arithmetic is done in this block except the FIFO pointers and count.

Optional Feature:
ALU_ISSUE_STATS_EN.
- Defined: adds outputs stat_ops[15:0] and stat_divz[7:0].
  - stat_ops increments on every DRIVE cycle.
  - stat_divz increments on every trapped divide-by-zero.
  - Both saturate at all-ones (no wrap) and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams ADD=4'h0, INC, SUB, DEC, MUL, DIV=4'h5, SHL, SHR, AND, OR, INV, NAND, NOR, XOR, XNOR, BUF=4'hF;
  - width constants OPW=8, RESW=16, CMDW=4;
  - the FSM state encoding IDLE/DRIVE/RESP.
- Sub-module alu_issue_fifo: generic synchronous FIFO, parameterised by width (20 bits: cmd+a+b) and DEPTH, with the same clk/rst_n; provides full, empty and count.

Test Plan:
- ADD a=200 b=100, res_ready=1 -> res_valid in cycle k+3, res_data=16'd300, res_cmd=0, res_err=0; alu_oe high for exactly 1 cycle.
- MUL a=255 b=255 -> res_data=16'hFE01.
- DIV a=7 b=0 -> alu_oe stays 0, res_data=16'hFFFF, res_err=1; the next queued SUB a=9 b=4 gives 16'd5 with res_err=0.
- res_ready=0, push 6 ops (DEPTH=4) -> 5 accepted, in_ready low from the cycle after the 5th accept; then res_ready=1 -> all 5 results in push order, one every 2 cycles.
- Mid-DRIVE rst_n low for 1 cycle -> alu_oe 0 immediately, res_valid 0, in_ready 1 after release, no stale result emitted.
- With ALU_ISSUE_STATS_EN: 3 ops including 1 DIV-by-0 -> stat_ops=3, stat_divz=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, widths, FSM encoding and operation payload for the ALU issue controller.
package alu_pkg;

  localparam int unsigned OPW    = 8;
  localparam int unsigned RESW   = 16;
  localparam int unsigned CMDW   = 4;
  localparam int unsigned OPBITS = CMDW + 2 * OPW;

  localparam logic [CMDW-1:0] ADD  = 4'h0;
  localparam logic [CMDW-1:0] INC  = 4'h1;
  localparam logic [CMDW-1:0] SUB  = 4'h2;
  localparam logic [CMDW-1:0] DEC  = 4'h3;
  localparam logic [CMDW-1:0] MUL  = 4'h4;
  localparam logic [CMDW-1:0] DIV  = 4'h5;
  localparam logic [CMDW-1:0] SHL  = 4'h6;
  localparam logic [CMDW-1:0] SHR  = 4'h7;
  localparam logic [CMDW-1:0] AND  = 4'h8;
  localparam logic [CMDW-1:0] OR   = 4'h9;
  localparam logic [CMDW-1:0] INV  = 4'hA;
  localparam logic [CMDW-1:0] NAND = 4'hB;
  localparam logic [CMDW-1:0] NOR  = 4'hC;
  localparam logic [CMDW-1:0] XOR  = 4'hD;
  localparam logic [CMDW-1:0] XNOR = 4'hE;
  localparam logic [CMDW-1:0] BUF  = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMDW-1:0] cmd;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
  } op_t;

  // Divide-by-zero is answered locally instead of being issued to the ALU.
  function automatic logic is_div_zero(input op_t op);
    return (op.cmd == DIV) && (op.b == '0);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Operation-in and result-out valid/ready handshakes of the ALU issue controller.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [CMDW-1:0] in_cmd;
  logic [OPW-1:0]  in_a;
  logic [OPW-1:0]  in_b;

  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] res_data;
  logic [CMDW-1:0] res_cmd;
  logic            res_err;

  modport master (
    output in_valid, in_cmd, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_cmd, res_err
  );

  modport slave (
    input  in_valid, in_cmd, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_cmd, res_err
  );

endinterface

// File: rtl/alu_issue_fifo.sv
// Generic synchronous FIFO; push is ignored when full and pop when empty.
module alu_issue_fifo #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally; the extra count bit separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues ALU operations and issues them one at a time, capturing a registered result.
// Optional ALU_ISSUE_STATS_EN adds saturating issue / divide-by-zero counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [CMDW-1:0] alu_cmd,
  output logic            alu_oe,
  input  logic [RESW-1:0] alu_dout
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]     stat_ops,
  output logic [7:0]      stat_divz
`endif
);

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic            alu_oe_q, alu_oe_d;
  logic            res_valid_q, res_valid_d;
  logic [RESW-1:0] res_data_q, res_data_d;
  logic [CMDW-1:0] res_cmd_q, res_cmd_d;
  logic            res_err_q, res_err_d;

  op_t             fifo_din, fifo_dout;
  logic            fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;
  logic            divz;

  assign fifo_din  = '{cmd: bus.in_cmd, a: bus.in_a, b: bus.in_b};
  assign fifo_push = bus.in_valid && bus.in_ready;
  assign divz      = is_div_zero(op_q);

  alu_issue_fifo #(
    .W     (OPBITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    alu_oe_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cmd_d   = res_cmd_q;
    res_err_d   = res_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        res_valid_d = 1'b1;
        res_cmd_d   = op_q.cmd;
        res_err_d   = divz;
        res_data_d  = divz ? '1 : alu_dout;
        state_d     = RESP;
      end
      RESP: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = DRIVE;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Output-enable is registered alongside the op so it covers exactly the DRIVE cycle.
    if (fifo_pop) begin
      op_d     = fifo_dout;
      alu_oe_d = !is_div_zero(fifo_dout);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      alu_oe_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cmd_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      alu_oe_q    <= alu_oe_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cmd_q   <= res_cmd_d;
      res_err_q   <= res_err_d;
    end
  end

  // Cross-check the flag and count views of the queue.
  always_ff @(posedge clk) begin
    if (rst_n) assert (fifo_empty == (fifo_count == '0));
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_cmd   = res_cmd_q;
  assign bus.res_err   = res_err_q;
  assign alu_a         = op_q.a;
  assign alu_b         = op_q.b;
  assign alu_cmd       = op_q.cmd;
  assign alu_oe        = alu_oe_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [7:0]  stat_divz_q, stat_divz_d;

  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_divz_d = stat_divz_q;
    if (state_q == DRIVE && stat_ops_q != '1)          stat_ops_d  = stat_ops_q + 16'(1);
    if (state_q == DRIVE && divz && stat_divz_q != '1) stat_divz_d = stat_divz_q + 8'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q  <= '0;
      stat_divz_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_divz_q <= stat_divz_d;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_divz = stat_divz_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural tri-stated ALU.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  wire  [15:0] alu_dout;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_divz;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cmd  (alu_cmd),
    .alu_oe   (alu_oe),
    .alu_dout (alu_dout)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_divz (stat_divz)
`endif
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'h0: return 16'(a) + 16'(b);
      4'h1: return 16'(a) + 16'd1;
      4'h2: return 16'(a) - 16'(b);
      4'h3: return 16'(a) - 16'd1;
      4'h4: return 16'(a) * 16'(b);
      4'h5: return (b == 8'd0) ? 16'd0 : 16'(a / b);
      4'h6: return 16'(a) << 1;
      4'h7: return 16'(a >> 1);
      4'h8: return 16'(a & b);
      4'h9: return 16'(a | b);
      4'hA: return 16'(~a);
      4'hB: return 16'(~(a & b));
      4'hC: return 16'(~(a | b));
      4'hD: return 16'(a ^ b);
      4'hE: return 16'(~(a ^ b));
      default: return 16'(a);
    endcase
  endfunction

  assign alu_dout = alu_oe ? alu_fn(alu_cmd, alu_a, alu_b) : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [3:0]  cap_cmd [6];
  logic [7:0]  cap_a   [6];
  logic [7:0]  cap_b   [6];
  logic [15:0] cap_res [6];

  initial begin
    cap_cmd = '{4'h0, 4'h2, 4'h8, 4'h9, 4'hD, 4'h1};
    cap_a   = '{8'd10, 8'd10, 8'hF0, 8'h0F, 8'hAA, 8'd1};
    cap_b   = '{8'd5, 8'd3, 8'h3C, 8'h30, 8'hFF, 8'd0};
    cap_res = '{16'd15, 16'd7, 16'h0030, 16'h003F, 16'h0055, 16'd2};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_cmd    = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_alu_oe", 32'(alu_oe), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ADD 200+100: oe one cycle after accept, result the cycle after that
    bus.res_ready = 1'b1;
    offer(4'h0, 8'd200, 8'd100);
    tick();
    bus.in_valid = 1'b0;
    check("add_oe_accept", 32'(alu_oe), 32'd0);
    tick();
    check("add_oe_drive", 32'(alu_oe), 32'd1);
    check("add_alu_a", 32'(alu_a), 32'd200);
    check("add_alu_b", 32'(alu_b), 32'd100);
    check("add_alu_cmd", 32'(alu_cmd), 32'd0);
    check("add_valid_early", 32'(bus.res_valid), 32'd0);
    tick();
    check("add_oe_after", 32'(alu_oe), 32'd0);
    check("add_valid", 32'(bus.res_valid), 32'd1);
    check("add_data", 32'(bus.res_data), 32'd300);
    check("add_cmd", 32'(bus.res_cmd), 32'd0);
    check("add_err", 32'(bus.res_err), 32'd0);
    tick();
    check("add_valid_drop", 32'(bus.res_valid), 32'd0);

    // MUL 255*255
    offer(4'h4, 8'd255, 8'd255);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mul_oe", 32'(alu_oe), 32'd1);
    tick();
    check("mul_valid", 32'(bus.res_valid), 32'd1);
    check("mul_data", 32'(bus.res_data), 32'hFE01);
    check("mul_cmd", 32'(bus.res_cmd), 32'd4);
    tick();

    // DIV 7/0 trapped, followed by queued SUB 9-4
    offer(4'h5, 8'd7, 8'd0);
    tick();
    offer(4'h2, 8'd9, 8'd4);
    tick();
    bus.in_valid = 1'b0;
    check("divz_oe_drive", 32'(alu_oe), 32'd0);
    check("divz_alu_cmd", 32'(alu_cmd), 32'd5);
    tick();
    check("divz_valid", 32'(bus.res_valid), 32'd1);
    check("divz_data", 32'(bus.res_data), 32'hFFFF);
    check("divz_err", 32'(bus.res_err), 32'd1);
    check("divz_cmd", 32'(bus.res_cmd), 32'd5);
    check("divz_oe_resp", 32'(alu_oe), 32'd0);
    tick();
    check("sub_valid_drop", 32'(bus.res_valid), 32'd0);
    check("sub_oe", 32'(alu_oe), 32'd1);
    check("sub_alu_cmd", 32'(alu_cmd), 32'd2);
    tick();
    check("sub_valid", 32'(bus.res_valid), 32'd1);
    check("sub_data", 32'(bus.res_data), 32'd5);
    check("sub_err", 32'(bus.res_err), 32'd0);
    tick();
    check("sub_idle", 32'(bus.res_valid), 32'd0);

    // DIV with non-zero divisor is issued normally
    offer(4'h5, 8'd9, 8'd3);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("div_oe", 32'(alu_oe), 32'd1);
    tick();
    check("div_data", 32'(bus.res_data), 32'd3);
    check("div_err", 32'(bus.res_err), 32'd0);
    tick();

    // Capacity: five accepted with res_ready low, sixth refused
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(cap_cmd[i], cap_a[i], cap_b[i]);
      tick();
      check($sformatf("cap_in_ready_%0d", i), 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    bus.in_valid = 1'b0;
    check("cap_valid_0", 32'(bus.res_valid), 32'd1);
    check("cap_data_0", 32'(bus.res_data), 32'(cap_res[0]));
    bus.res_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("cap_gap_%0d", i), 32'(bus.res_valid), 32'd0);
      tick();
      check($sformatf("cap_valid_%0d", i), 32'(bus.res_valid), 32'd1);
      check($sformatf("cap_data_%0d", i), 32'(bus.res_data), 32'(cap_res[i]));
      check($sformatf("cap_cmd_%0d", i), 32'(bus.res_cmd), 32'(cap_cmd[i]));
    end
    tick();
    check("cap_drain_valid", 32'(bus.res_valid), 32'd0);
    check("cap_drain_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    check("cap_no_sixth", 32'(bus.res_valid), 32'd0);
    check("cap_no_sixth_oe", 32'(alu_oe), 32'd0);

    // Reset asserted in the middle of a DRIVE cycle with one op queued behind it
    offer(4'h0, 8'd3, 8'd4);
    tick();
    offer(4'h9, 8'd1, 8'd2);
    tick();
    bus.in_valid = 1'b0;
    check("mrst_oe_before", 32'(alu_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_oe_async", 32'(alu_oe), 32'd0);
    check("mrst_valid", 32'(bus.res_valid), 32'd0);
    check("mrst_alu_a", 32'(alu_a), 32'd0);
    tick();
    rst_n = 1'b1;
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mrst_stale_valid_%0d", i), 32'(bus.res_valid), 32'd0);
      check($sformatf("mrst_stale_oe_%0d", i), 32'(alu_oe), 32'd0);
    end

`ifdef ALU_ISSUE_STATS_EN
    check("stat_ops_rst", 32'(stat_ops), 32'd0);
    offer(4'h0, 8'd1, 8'd2);
    tick();
    offer(4'h5, 8'd7, 8'd0);
    tick();
    offer(4'h1, 8'd5, 8'd0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("stat_ops", 32'(stat_ops), 32'd3);
    check("stat_divz", 32'(stat_divz), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
